// File: rtl/sys_mem_unit_if.sv
// sys_mem_unit_if: request/response link between the memory interface unit
// (master) and the system memory (slave).
//   read_req / write_req : level-held requests, dropped after mem_resp is seen
//   addr                 : 14-bit byte address
//   datatomem            : 16-bit little-endian write word
//   datafrommem          : 8-bit read data
//   mem_resp             : one-cycle completion pulse
//   busy                 : memory is between acceptance and handshake release
//   req_err              : both requests were high at acceptance
interface sys_mem_unit_if;
  logic        read_req;
  logic        write_req;
  logic [13:0] addr;
  logic [15:0] datatomem;
  logic [7:0]  datafrommem;
  logic        mem_resp;
  logic        busy;
  logic        req_err;

  modport master (
    output read_req, write_req, addr, datatomem,
    input  datafrommem, mem_resp, busy, req_err
  );

  modport slave (
    input  read_req, write_req, addr, datatomem,
    output datafrommem, mem_resp, busy, req_err
  );
endinterface

// File: rtl/sys_mem_unit.sv
// sys_mem_unit: 16 KB byte-addressed system memory with a fixed-latency
// request/response handshake. One access at a time: a read returns mem[A],
// a write commits datatomem[7:0] at A and datatomem[15:8] at A+1 (wrapping).
// Ports:
//   clk      : clock
//   reset_n  : synchronous active-low reset (array contents are not reset)
//   bus      : sys_mem_unit_if.slave request/response link
// Parameters:
//   LATENCY  : cycles from acceptance to mem_resp (1..15)
//   DEPTH    : bytes of storage (2^14)
module sys_mem_unit #(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 16384
) (
  input  logic           clk,
  input  logic           reset_n,
  sys_mem_unit_if.slave  bus
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESP    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t             state, next_state;
  logic [CNT_W-1:0]   cnt_p0;
  logic               accept;
  logic               both_req;

  // Request latched at acceptance; data-path registers carry no reset.
  logic               op_wr_p0;
  logic [13:0]        addr_p0;
  logic [15:0]        data_p0;

  logic [7:0]         mem [0:DEPTH-1];
  logic [7:0]         rdata_p1;
  logic               req_err_p1;

  logic               rd_load;
  logic [13:0]        rd_addr;

  assign accept   = (state == IDLE) && (bus.read_req || bus.write_req);
  assign both_req = bus.read_req && bus.write_req;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) next_state = (LATENCY == 1) ? RESP : WAIT;
      end
      WAIT: begin
        // Counter is loaded with LATENCY-1; the last WAIT cycle sees 1.
        if (cnt_p0 <= CNT_W'(1)) next_state = RESP;
      end
      RESP: begin
        next_state = RELEASE;
      end
      RELEASE: begin
        if (!bus.read_req && !bus.write_req) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.mem_resp    = (state == RESP);
    bus.busy        = (state != IDLE);
    bus.req_err     = req_err_p1;
    bus.datafrommem = rdata_p1;
  end

  // Latency counter and error pulse (control, reset)
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_p0     <= '0;
      req_err_p1 <= 1'b0;
    end else begin
      req_err_p1 <= accept && both_req;
      if (accept)
        cnt_p0 <= CNT_W'(LATENCY - 1);
      else if (state == WAIT && cnt_p0 != '0)
        cnt_p0 <= cnt_p0 - CNT_W'(1);
    end
  end

  // ---- Stage p0: acceptance latch (write wins on simultaneous requests) ----
  always_ff @(posedge clk) begin
    if (accept) begin
      op_wr_p0 <= bus.write_req;
      addr_p0  <= bus.addr;
      data_p0  <= bus.datatomem;
    end
  end

  // ---- Stage p1: array access ----
  // The read is registered on the edge entering RESP so the byte is
  // presented together with mem_resp. With LATENCY=1 that edge is the
  // acceptance edge itself, so the live request fields are used.
  always_comb begin
    rd_addr = (state == IDLE) ? bus.addr : addr_p0;
    rd_load = 1'b0;
    if (next_state == RESP && state != RESP)
      rd_load = (state == IDLE) ? !bus.write_req : !op_wr_p0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)     rdata_p1 <= 8'h00;
    else if (rd_load) rdata_p1 <= mem[rd_addr];
  end

  // Commit at the end of RESP; a coinciding reset discards the write.
  always_ff @(posedge clk) begin
    if (reset_n && state == RESP && op_wr_p0) begin
      mem[addr_p0]         <= data_p0[7:0];
      mem[addr_p0 + 14'd1] <= data_p0[15:8];
    end
  end

endmodule
